// File: rtl/reverse_pkg.sv
// Shared definitions for the streaming frame reverser: state codes and a
// generic bit-reversal helper.
package reverse_pkg;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        StFill  = ST_FILL,
        StLoad  = ST_LOAD,
        StDrain = ST_DRAIN
    } state_e;

    // Widest word the helper handles.
    localparam int unsigned MaxW = 64;
    localparam int unsigned IdxW = $clog2(MaxW);

    // Reverse the low w bits of d; bits at and above w come back as zero.
    function automatic logic [MaxW-1:0] bitrev(input logic [MaxW-1:0] d, input int unsigned w);
        logic [MaxW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxW; i++) begin
            if (i < w) begin
                r[IdxW'(i)] = d[IdxW'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reverse_frame_ctrl_bit_reverse_word.sv
// Combinational word bit reversal: out bit i takes in bit W-1-i.
module bit_reverse_word #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    // Pure wiring permutation, no logic.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign out_o[i] = in_i[W-1-i];
    end

endmodule

// File: rtl/reverse_frame_ctrl.sv
// Streaming frame reverser: collects up to DEPTH words, then replays them
// last-word-first with each word bit-reversed.
module reverse_frame_ctrl
    import reverse_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    input  logic         s_last_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o,
    output logic         m_last_o,
    output logic         busy_o,
    output logic         trunc_err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    state_e          state_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            m_valid_q;
    logic            m_last_q;
    logic [W-1:0]    m_data_q;
    logic            trunc_err_q;

    logic [W-1:0]    frame_mem [DEPTH];

    logic            s_accept;
    logic            m_accept;
    logic            wr_at_end;
    logic            frame_end;
    logic [PtrW-1:0] rd_addr;
    logic [W-1:0]    rd_word;
    logic [W-1:0]    rev_word;

    assign s_ready_o = (state_q == StFill) && !rst_i;
    assign s_accept  = s_valid_i && s_ready_o;
    assign m_accept  = m_valid_q && m_ready_i;
    assign wr_at_end = (wr_ptr_q == PtrW'(DEPTH - 1));
    assign frame_end = s_accept && (s_last_i || wr_at_end);

    // LOAD fetches the newest word (cnt-1); DRAIN walks rd_ptr downwards.
    assign rd_addr = (state_q == StLoad) ? PtrW'(cnt_q - CntW'(1)) : rd_ptr_q;
    assign rd_word = frame_mem[rd_addr];

    bit_reverse_word #(
        .W (W)
    ) u_bit_reverse_word (
        .in_i  (rd_word),
        .out_o (rev_word)
    );

    // Frame buffer write port; contents are not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (s_accept) begin
            frame_mem[wr_ptr_q] <= s_data_i;
        end
    end

    // Control FSM, pointers and registered output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFill;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            trunc_err_q <= 1'b0;
        end else begin
            // Buffer filled without a last marker: flag it for one cycle.
            trunc_err_q <= frame_end && !s_last_i;
            unique case (state_q)
                StFill: begin
                    if (s_accept) begin
                        if (frame_end) begin
                            cnt_q    <= CntW'(wr_ptr_q) + CntW'(1);
                            wr_ptr_q <= '0;
                            state_q  <= StLoad;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PtrW'(1);
                        end
                    end
                end
                StLoad: begin
                    m_data_q  <= rev_word;
                    m_last_q  <= (cnt_q == CntW'(1));
                    m_valid_q <= 1'b1;
                    // Wraps for a one-word frame; never read in that case.
                    rd_ptr_q  <= PtrW'(cnt_q - CntW'(2));
                    state_q   <= StDrain;
                end
                StDrain: begin
                    if (m_accept) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= StFill;
                        end else begin
                            m_data_q <= rev_word;
                            m_last_q <= (rd_ptr_q == '0);
                            rd_ptr_q <= rd_ptr_q - PtrW'(1);
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign m_valid_o   = m_valid_q;
    assign m_last_o    = m_last_q;
    assign m_data_o    = m_data_q;
    assign trunc_err_o = trunc_err_q;
    assign busy_o      = (state_q != StFill);

endmodule
